// File: rtl/adc_cap_pkg.sv
// adc_cap_pkg: shared FSM encoding and default widths for the ADC trigger capture block.
package adc_cap_pkg;
   typedef enum logic [2:0] {IDLE, PREFILL, WAIT_TRIG, POST, READOUT} cap_state_t;
   localparam int DEF_DATA_W = 14;
   localparam int DEF_ADDR_W = 10;
endpackage

// File: rtl/cap_ram.sv
// cap_ram: simple dual-port sample ring, sync write and registered read (1-cycle latency).
module cap_ram #(
   parameter int DATA_W = 14,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);
   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= mem[rd_addr];
   end
endmodule

// File: rtl/adc_trig_capture.sv
// adc_trig_capture: rings one ADC channel around a threshold/force trigger,
// then replays the pre/post window as a valid/ready stream.
module adc_trig_capture
   import adc_cap_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              CLKDIV,
   input  logic              RST,
   input  logic              CE,
   input  logic              aligned,
   input  logic [DATA_W-1:0] sample_i,
   input  logic              arm,
   input  logic              trig_force,
   input  logic [DATA_W-1:0] threshold,
   input  logic [ADDR_W-1:0] pre_len,
   input  logic [ADDR_W-1:0] post_len,
   output logic              busy,
   output logic              triggered,
   output logic              err,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   output logic              m_last,
   input  logic              m_ready
);
   cap_state_t state, state_nx;
   logic s, cap, trig, wr_en, rd_en, pop, rd_pend, rd_pend_last, prev_ok;
   logic [ADDR_W-1:0] wr_ptr, rd_ptr, pre_q, post_q, cnt, post_clip;
   logic [ADDR_W:0] len_sum, rd_left;
   logic [DATA_W-1:0] prev, rd_data;
   logic [DATA_W:0] head, tail;
   logic [1:0] fcnt;

   assign s = CE & aligned;
   assign cap = state == PREFILL || state == WAIT_TRIG || state == POST;
   assign wr_en = cap & s;
   assign trig = state == WAIT_TRIG && s && (trig_force || (prev_ok && prev < threshold && sample_i >= threshold));
   assign len_sum = {1'b0, pre_len} + {1'b0, post_len};
   // An oversized window shrinks post so that pre + post = DEPTH-1, i.e. post = ~pre.
   assign post_clip = len_sum[ADDR_W] ? ~pre_len : post_len;
   assign pop = m_valid & m_ready;
   // Read only when the word landing next cycle is sure of a slot in the 2-entry skid.
   assign rd_en = state == READOUT && rd_left != '0 && fcnt + {1'b0, rd_pend} <= {1'b0, pop} + 2'd1;
   assign busy = state != IDLE;
   assign m_valid = fcnt != 2'd0;
   assign m_data = head[DATA_W-1:0];
   assign m_last = m_valid & head[DATA_W];

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:      if (arm) state_nx = pre_len == '0 ? WAIT_TRIG : PREFILL;
         PREFILL:   if (s && cnt == pre_q - 1'b1) state_nx = WAIT_TRIG;
         WAIT_TRIG: if (trig) state_nx = post_q == '0 ? READOUT : POST;
         POST:      if (s && cnt == post_q - 1'b1) state_nx = READOUT;
         READOUT:   if (pop && m_last) state_nx = IDLE;
         default:   state_nx = IDLE;
      endcase
      if (cap && !aligned) state_nx = IDLE;
   end

   always_ff @(posedge CLKDIV or posedge RST) begin
      if (RST) begin
         state <= IDLE;
         {wr_ptr, rd_ptr, pre_q, post_q, cnt, rd_left} <= '0;
         {prev, prev_ok, triggered, err, rd_pend, rd_pend_last} <= '0;
         {head, tail, fcnt} <= '0;
      end else begin
         state <= state_nx;
         if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
            prev <= sample_i;
            prev_ok <= 1'b1;
            cnt <= state == WAIT_TRIG || state_nx != state ? '0 : cnt + 1'b1;
         end
         if (state == IDLE && arm) begin
            pre_q <= pre_len;
            post_q <= post_clip;
            cnt <= '0;
            prev_ok <= 1'b0;
            triggered <= 1'b0;
            err <= 1'b0;
            rd_left <= {1'b0, pre_len} + {1'b0, post_clip} + 1'b1;
         end
         if (trig) begin
            triggered <= 1'b1;
            rd_ptr <= wr_ptr - pre_q;
         end
         if (cap && !aligned) err <= 1'b1;
         if (rd_en) begin
            rd_ptr <= rd_ptr + 1'b1;
            rd_left <= rd_left - 1'b1;
         end
         rd_pend <= rd_en;
         rd_pend_last <= rd_left == (ADDR_W+1)'(1);
         if (pop && rd_pend) begin
            if (fcnt == 2'd1) head <= {rd_pend_last, rd_data};
            else begin
               head <= tail;
               tail <= {rd_pend_last, rd_data};
            end
         end else if (pop) begin
            head <= tail;
            fcnt <= fcnt - 1'b1;
         end else if (rd_pend) begin
            if (fcnt == 2'd0) head <= {rd_pend_last, rd_data};
            else tail <= {rd_pend_last, rd_data};
            fcnt <= fcnt + 1'b1;
         end
      end
   end

   cap_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) ram (
      .clk(CLKDIV), .wr_en(wr_en), .wr_addr(wr_ptr), .wr_data(sample_i),
      .rd_en(rd_en), .rd_addr(rd_ptr), .rd_data(rd_data)
   );
endmodule

// File: tb/tb_adc_trig_capture.sv
// tb_adc_trig_capture: randomized bench; the reference keeps every strobed sample since arm
// and cuts the window out of that list around the first qualifying trigger.
module tb_adc_trig_capture;
   localparam int DW = 14, AW = 10, DEPTH = 1 << AW;
   logic clk = 0, rst = 1, ce = 0, aligned = 1, arm = 0, trig_force = 0, m_ready = 0;
   logic [DW-1:0] sample = '0, threshold = '0, m_data;
   logic [AW-1:0] pre_len = '0, post_len = '0;
   logic busy, triggered, err, m_valid, m_last;
   int checks = 0, failures = 0, cyc = 0;
   logic [DW-1:0] exp_q[$], got_q[$];
   bit got_l[$];
   int unstable, first_v, first_hs, last_hs, fin_cyc;
   bit tmo;

   always #5 clk = ~clk;

   adc_trig_capture dut (
      .CLKDIV(clk), .RST(rst), .CE(ce), .aligned(aligned), .sample_i(sample), .arm(arm),
      .trig_force(trig_force), .threshold(threshold), .pre_len(pre_len), .post_len(post_len),
      .busy(busy), .triggered(triggered), .err(err), .m_data(m_data), .m_valid(m_valid),
      .m_last(m_last), .m_ready(m_ready)
   );

   function automatic logic [DW-1:0] gen(input int mode, input int idx);
      return mode == 0 ? DW'(idx) : DW'($urandom_range(4095));
   endfunction

   task automatic capture(input int pre, input int post, input int th, input int mode, input int ce_pct,
                          input int frc_pct, input bit frc_first, input int rdy_pct);
      logic [DW-1:0] hist[$];
      logic [DW-1:0] pd;
      int postc, t, n;
      bit done, fin, stall, pl;
      exp_q.delete(); got_q.delete(); got_l.delete();
      unstable = 0; first_v = -1; first_hs = -1; last_hs = -1; fin_cyc = -1; tmo = 1;
      postc = pre + post > DEPTH - 1 ? DEPTH - 1 - pre : post;
      t = -1; done = 0; fin = 0; stall = 0; pd = '0; pl = 0;
      @(negedge clk); cyc++;
      threshold = DW'(th); pre_len = AW'(pre); post_len = AW'(post);
      arm = 1; ce = 0; trig_force = 0; m_ready = 0; aligned = 1;
      for (int c = 0; c < 20000; c++) begin
         @(negedge clk); cyc++;
         arm = 0;
         if (fin) begin
            tmo = 0;
            break;
         end
         m_ready = $urandom_range(99) < rdy_pct;
         if (stall && (!m_valid || m_data !== pd || m_last !== pl)) unstable++;
         if (m_valid && first_v < 0) first_v = cyc;
         if (m_valid && m_ready) begin
            got_q.push_back(m_data);
            got_l.push_back(m_last);
            if (first_hs < 0) first_hs = cyc;
            last_hs = cyc;
            fin = m_last;
         end
         stall = m_valid && !m_ready; pd = m_data; pl = m_last;
         if (done) begin
            ce = 0; trig_force = 0;
         end else begin
            ce = $urandom_range(99) < ce_pct;
            sample = gen(mode, hist.size());
            trig_force = (frc_first && hist.size() == 0) || ($urandom_range(99) < frc_pct);
            if (ce) begin
               n = hist.size();
               hist.push_back(sample);
               if (t < 0 && n >= pre && (trig_force || (n > 0 && int'(hist[n-1]) < th && int'(sample) >= th))) t = n;
               if (t >= 0 && n == t + postc) begin
                  done = 1; fin_cyc = cyc;
                  for (int i = t - pre; i <= t + postc; i++) exp_q.push_back(hist[i]);
               end
            end
         end
      end
      ce = 0; trig_force = 0; m_ready = 0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if ({busy, triggered, err, m_valid, m_last, m_data} !== '0) begin
         failures++; $display("FAIL reset_in got=%h exp=0", {busy, triggered, err, m_valid, m_last, m_data});
      end
      rst = 0;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, triggered, err, m_valid, m_last, m_data} !== '0) begin
         failures++; $display("FAIL reset_out got=%h exp=0", {busy, triggered, err, m_valid, m_last, m_data});
      end
   endtask

   task automatic test_ramp();
      capture(4, 3, 1000, 0, 100, 0, 0, 100);
      checks++; if (tmo) begin failures++; $display("FAIL ramp_timeout got=1 exp=0"); end
      checks++; if (got_q.size() != 8) begin failures++; $display("FAIL ramp_len got=%0d exp=8", got_q.size()); end
      for (int i = 0; i < got_q.size() && i < 8; i++) begin
         checks++;
         if (got_q[i] !== DW'(996 + i) || got_l[i] !== (i == 7)) begin
            failures++; $display("FAIL ramp_word[%0d] got=%0d/%0b exp=%0d/%0b", i, got_q[i], got_l[i], 996 + i, i == 7);
         end
      end
      checks++; if (first_v - fin_cyc != 3) begin failures++; $display("FAIL ramp_latency got=%0d exp=3", first_v - fin_cyc); end
      checks++; if (last_hs - first_hs != 7) begin failures++; $display("FAIL ramp_rate got=%0d exp=7", last_hs - first_hs); end
      checks++; if (triggered !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL ramp_flags got=%b%b exp=10", triggered, busy); end
   endtask

   task automatic test_force_n1();
      capture(0, 0, 16383, 1, 100, 0, 1, 100);
      checks++; if (tmo) begin failures++; $display("FAIL n1_timeout got=1 exp=0"); end
      checks++;
      if (got_q.size() != 1) begin
         failures++; $display("FAIL n1_len got=%0d exp=1", got_q.size());
      end else if (got_q[0] !== exp_q[0] || got_l[0] !== 1'b1) begin
         failures++; $display("FAIL n1_word got=%0d/%0b exp=%0d/1", got_q[0], got_l[0], exp_q[0]);
      end
      checks++; if (first_v - fin_cyc != 3) begin failures++; $display("FAIL n1_latency got=%0d exp=3", first_v - fin_cyc); end
   endtask

   task automatic test_clip_wrap();
      capture(1000, 100, 1500, 0, 100, 0, 0, 100);
      checks++; if (tmo) begin failures++; $display("FAIL clip_timeout got=1 exp=0"); end
      checks++; if (got_q.size() != 1024) begin failures++; $display("FAIL clip_len got=%0d exp=1024", got_q.size()); end
      for (int i = 0; i < got_q.size() && i < 1024; i++) begin
         checks++;
         if (got_q[i] !== DW'(500 + i) || got_l[i] !== (i == 1023)) begin
            failures++; $display("FAIL clip_word[%0d] got=%0d/%0b exp=%0d/%0b", i, got_q[i], got_l[i], 500 + i, i == 1023);
            break;
         end
      end
      checks++; if (last_hs - first_hs != 1023) begin failures++; $display("FAIL clip_rate got=%0d exp=1023", last_hs - first_hs); end
   endtask

   task automatic test_backpressure();
      for (int k = 0; k < 6; k++) begin
         capture($urandom_range(12), $urandom_range(12), 2048, 1, 70, 3, 0, 50);
         checks++; if (tmo) begin failures++; $display("FAIL bp_timeout[%0d] got=1 exp=0", k); end
         checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL bp_len[%0d] got=%0d exp=%0d", k, got_q.size(), exp_q.size()); end
         for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i] || got_l[i] !== (i == exp_q.size() - 1)) begin
               failures++; $display("FAIL bp_word[%0d][%0d] got=%0d/%0b exp=%0d/%0b", k, i, got_q[i], got_l[i], exp_q[i], i == exp_q.size() - 1);
               break;
            end
         end
         checks++; if (unstable != 0) begin failures++; $display("FAIL bp_stable[%0d] got=%0d exp=0", k, unstable); end
         checks++; if (first_v - fin_cyc != 3) begin failures++; $display("FAIL bp_latency[%0d] got=%0d exp=3", k, first_v - fin_cyc); end
      end
   endtask

   task automatic test_align_loss();
      bit seen;
      @(negedge clk);
      pre_len = 2; post_len = 3; threshold = 16000; arm = 1; ce = 0; aligned = 1;
      @(negedge clk);
      arm = 0; ce = 1; sample = 10;
      repeat (5) @(negedge clk);
      checks++; if (busy !== 1'b1 || err !== 1'b0) begin failures++; $display("FAIL al_wait got=%b%b exp=10", busy, err); end
      aligned = 0;
      @(negedge clk);
      checks++; if (err !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL al_err got=%b%b exp=10", err, busy); end
      aligned = 1; ce = 0; seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (m_valid) seen = 1;
      end
      checks++; if (seen) begin failures++; $display("FAIL al_novalid got=1 exp=0"); end
      arm = 1;
      @(negedge clk);
      arm = 0;
      checks++; if (err !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL al_rearm got=%b%b exp=01", err, busy); end
      rst = 1;
      @(negedge clk);
      rst = 0;
   endtask

   task automatic test_rst_mid();
      @(negedge clk);
      pre_len = 2; post_len = 50; threshold = 10; arm = 1; ce = 0; aligned = 1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         arm = 0; ce = 1; sample = DW'(i);
      end
      @(negedge clk);
      ce = 0;
      checks++; if (triggered !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL rp_post got=%b%b exp=11", triggered, busy); end
      #2 rst = 1;
      #1;
      checks++;
      if ({busy, triggered, err, m_valid, m_last, m_data} !== '0) begin
         failures++; $display("FAIL rp_rst got=%h exp=0", {busy, triggered, err, m_valid, m_last, m_data});
      end
      @(negedge clk);
      rst = 0;
      pre_len = 0; post_len = 0; threshold = 16000; arm = 1; m_ready = 0;
      @(negedge clk);
      arm = 0; ce = 1; sample = 1234; trig_force = 1;
      @(negedge clk);
      ce = 0; trig_force = 0;
      repeat (5) @(negedge clk);
      checks++;
      if (m_valid !== 1'b1 || m_data !== DW'(1234) || m_last !== 1'b1) begin
         failures++; $display("FAIL rr_stall got=%b/%0d/%b exp=1/1234/1", m_valid, m_data, m_last);
      end
      #2 rst = 1;
      #1;
      checks++;
      if ({busy, triggered, err, m_valid, m_last, m_data} !== '0) begin
         failures++; $display("FAIL rr_rst got=%h exp=0", {busy, triggered, err, m_valid, m_last, m_data});
      end
      @(negedge clk);
      rst = 0;
      capture(4, 3, 1000, 0, 60, 0, 0, 100);
      checks++; if (tmo || got_q.size() != 8) begin failures++; $display("FAIL rearm_len got=%0d exp=8", got_q.size()); end
      for (int i = 0; i < got_q.size() && i < 8; i++) begin
         checks++;
         if (got_q[i] !== DW'(996 + i) || got_l[i] !== (i == 7)) begin
            failures++; $display("FAIL rearm_word[%0d] got=%0d/%0b exp=%0d/%0b", i, got_q[i], got_l[i], 996 + i, i == 7);
         end
      end
   endtask

   task automatic test_no_trig();
      @(negedge clk);
      pre_len = 0; post_len = 2; threshold = 1000; arm = 1; ce = 0; aligned = 1;
      @(negedge clk);
      arm = 0; ce = 1; sample = 3000;
      repeat (40) @(negedge clk);
      checks++; if (triggered !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL notrig got=%b%b exp=01", triggered, busy); end
      ce = 0; rst = 1;
      @(negedge clk);
      rst = 0;
   endtask

   initial begin
      test_reset();
      test_ramp();
      test_force_n1();
      test_clip_wrap();
      test_backpressure();
      test_align_loss();
      test_rst_mid();
      test_no_trig();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
